// File: rtl/video_sync_decoder.sv
// video_sync_decoder: recovers PAL field, line and pixel timing from a 3-bit
// composite level bus by width-classifying each sync pulse.
module video_sync_decoder #(
  parameter int MIN_PULSE  = 24,
  parameter int EQ_MAX     = 84,
  parameter int HS_MAX     = 300,
  parameter int BROAD_MIN  = 4,
  parameter int FIRST_LINE = 32,
  parameter int ROWS       = 256,
  parameter int H_START    = 252,
  parameter int H_END      = 1500
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [2:0]  video_in,
  output logic        hsync_pulse,
  output logic        field_start,
  output logic [8:0]  line_num,
  output logic [10:0] h_pos,
  output logic        de,
  output logic        vblank,
  output logic        locked
);

  typedef enum logic [2:0] {
    V_SEARCH,
    V_BROAD,
    V_POST,
    V_ACTIVE,
    V_TAIL
  } state_t;

  localparam logic [9:0]  WIDTH_ACCEPT = 10'(MIN_PULSE - 1);
  localparam logic [9:0]  WIDTH_EQ_MAX = 10'(EQ_MAX);
  localparam logic [9:0]  WIDTH_HS_MAX = 10'(HS_MAX);
  localparam logic [9:0]  WIDTH_SAT    = 10'h3FF;
  localparam logic [3:0]  BROAD_NEED   = 4'(BROAD_MIN);
  localparam logic [3:0]  BROAD_SAT    = 4'hF;
  localparam logic [8:0]  LINE_FIRST   = 9'(FIRST_LINE);
  localparam logic [8:0]  LINE_LAST    = 9'(FIRST_LINE + ROWS);
  localparam logic [8:0]  LINE_SAT     = 9'd510;
  localparam logic [10:0] COL_FIRST    = 11'(H_START);
  localparam logic [10:0] COL_LAST     = 11'(H_END);
  localparam logic [10:0] H_SAT        = 11'h7FF;

  logic [2:0]  sync1_q, sync2_q;
  state_t      state_q, state_d;
  logic [9:0]  width_q, width_d;
  logic        armed_q, armed_d;
  logic        in_pulse_q, in_pulse_d;
  logic [10:0] h_pos_q, h_pos_d;
  logic [3:0]  broad_cnt_q, broad_cnt_d;
  logic [8:0]  line_cnt_q, line_cnt_d;
  logic [8:0]  line_num_q, line_num_d;
  logic        locked_q, locked_d;
  logic        hsync_q, hsync_d;
  logic        field_q, field_d;

  logic is_sync, accept, classify;
  logic pulse_eq, pulse_hs, pulse_br;

  // Two-flop synchroniser; resets to the sync code so a pulse already in
  // progress at reset release is never mistaken for a fresh one.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1_q <= 3'b000;
      sync2_q <= 3'b000;
    end else begin
      sync1_q <= video_in;
      sync2_q <= sync1_q;
    end
  end

  assign is_sync  = (sync2_q == 3'b000);
  assign accept   = is_sync & armed_q & ~in_pulse_q & (width_q == WIDTH_ACCEPT);
  assign classify = ~is_sync & in_pulse_q;
  assign pulse_eq = (width_q < WIDTH_EQ_MAX);
  assign pulse_hs = (width_q >= WIDTH_EQ_MAX) && (width_q < WIDTH_HS_MAX);
  assign pulse_br = (width_q >= WIDTH_HS_MAX);

  // Pulse width measurement, glitch acceptance and horizontal position counter.
  always_comb begin
    armed_d    = armed_q;
    width_d    = width_q;
    in_pulse_d = in_pulse_q;
    h_pos_d    = h_pos_q;
    if (!is_sync) begin
      armed_d    = 1'b1;
      width_d    = '0;
      in_pulse_d = 1'b0;
    end else if (armed_q) begin
      if (width_q != WIDTH_SAT) width_d = width_q + 10'd1;
      if (accept) in_pulse_d = 1'b1;
    end
    if (accept) h_pos_d = '0;
    else if (h_pos_q != H_SAT) h_pos_d = h_pos_q + 11'd1;
  end

  // Vertical sync state machine driven by classified pulses, plus timeout.
  always_comb begin
    state_d     = state_q;
    broad_cnt_d = broad_cnt_q;
    line_cnt_d  = line_cnt_q;
    locked_d    = locked_q;
    hsync_d     = 1'b0;
    field_d     = 1'b0;
    if (classify) begin
      case (state_q)
        V_SEARCH: begin
          if (pulse_br) begin
            state_d     = V_BROAD;
            broad_cnt_d = 4'd1;
          end
        end
        V_BROAD: begin
          if (pulse_br) begin
            if (broad_cnt_q != BROAD_SAT) broad_cnt_d = broad_cnt_q + 4'd1;
          end else if (pulse_eq && (broad_cnt_q >= BROAD_NEED)) begin
            state_d    = V_POST;
            field_d    = 1'b1;
            locked_d   = 1'b1;
            line_cnt_d = 9'h1FF;
          end else begin
            state_d = V_SEARCH;
          end
        end
        V_POST: begin
          if (pulse_hs) begin
            state_d    = V_ACTIVE;
            hsync_d    = 1'b1;
            line_cnt_d = line_cnt_q + 9'd1;
          end else if (pulse_br) begin
            state_d     = V_BROAD;
            broad_cnt_d = 4'd1;
          end
        end
        V_ACTIVE: begin
          if (pulse_hs) begin
            hsync_d = 1'b1;
            if (line_cnt_q != LINE_SAT) line_cnt_d = line_cnt_q + 9'd1;
          end else if (pulse_eq) begin
            state_d = V_TAIL;
          end else begin
            state_d     = V_BROAD;
            broad_cnt_d = 4'd1;
          end
        end
        V_TAIL: begin
          if (pulse_br) begin
            state_d     = V_BROAD;
            broad_cnt_d = 4'd1;
          end else if (pulse_hs) begin
            state_d = V_SEARCH;
          end
        end
        default: state_d = V_SEARCH;
      endcase
    end
    if (h_pos_q == H_SAT) begin
      state_d = V_SEARCH;
      hsync_d = 1'b0;
      field_d = 1'b0;
    end
    if (state_d == V_SEARCH) begin
      locked_d    = 1'b0;
      broad_cnt_d = '0;
    end
    line_num_d = (state_d == V_ACTIVE) ? line_cnt_d : line_num_q;
  end

  // State register for the pulse tracker and the vertical state machine.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= V_SEARCH;
      width_q     <= '0;
      armed_q     <= 1'b0;
      in_pulse_q  <= 1'b0;
      h_pos_q     <= '0;
      broad_cnt_q <= '0;
      line_cnt_q  <= '0;
      line_num_q  <= '0;
      locked_q    <= 1'b0;
      hsync_q     <= 1'b0;
      field_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      width_q     <= width_d;
      armed_q     <= armed_d;
      in_pulse_q  <= in_pulse_d;
      h_pos_q     <= h_pos_d;
      broad_cnt_q <= broad_cnt_d;
      line_cnt_q  <= line_cnt_d;
      line_num_q  <= line_num_d;
      locked_q    <= locked_d;
      hsync_q     <= hsync_d;
      field_q     <= field_d;
    end
  end

  assign hsync_pulse = hsync_q;
  assign field_start = field_q;
  assign line_num    = line_num_q;
  assign h_pos       = h_pos_q;
  assign locked      = locked_q;
  assign vblank      = (state_q != V_ACTIVE);
  assign de          = (state_q == V_ACTIVE) &&
                       (line_num_q >= LINE_FIRST) && (line_num_q < LINE_LAST) &&
                       (h_pos_q >= COL_FIRST) && (h_pos_q < COL_LAST);

endmodule
